// File: rtl/bcd_display_counter.sv
// Four-digit BCD up/down counter with a built-in tick prescaler, feeding the seven-segment scan driver.
// Optional build macro BCD_SATURATE_EN: clamp at 9999/0000 instead of wrapping.
module bcd_display_counter #(
  parameter int TICK_DIV = 1000,
  parameter int PRESC_W  = 20
) (
  input  logic        Clk,
  input  logic        Aclr,
  input  logic        En,
  input  logic        Up_dn,
  input  logic        Load,
  input  logic [15:0] Load_val,
  output logic [15:0] Bcd,
  output logic        Tick,
  output logic        Carry
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [PRESC_W-1:0] presc;
  logic               step;
  logic [15:0]        step_val;
  logic               step_wrap;
  logic               ripple;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
    return {clamp_digit(v[15:12]), clamp_digit(v[11:8]),
            clamp_digit(v[7:4]),   clamp_digit(v[3:0])};
  endfunction

  assign step = En && (presc == PRESC_LAST);

  // Prescaler only advances while enabled and never self-clears on En=0.
  always_ff @(posedge Clk) begin
    if (Aclr) begin
      presc <= '0;
    end else if (Load) begin
      presc <= '0;
    end else if (En) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_ONE;
    end
  end

  // Digit ripple: a digit at its limit rolls over and passes the step on to the next digit.
  always_comb begin
    step_val  = Bcd;
    ripple    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ripple) begin
        if (Up_dn) begin
          if (Bcd[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = Bcd[4*i +: 4] + 4'd1;
            ripple             = 1'b0;
          end
        end else begin
          if (Bcd[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = Bcd[4*i +: 4] - 4'd1;
            ripple             = 1'b0;
          end
        end
      end
    end
    step_wrap = ripple;
`ifdef BCD_SATURATE_EN
    if (ripple) begin
      step_val = Bcd;
    end
`endif
  end

  // Load wins over a coincident step; the step is simply dropped.
  always_ff @(posedge Clk) begin
    if (Aclr) begin
      Bcd   <= 16'h0000;
      Tick  <= 1'b0;
      Carry <= 1'b0;
    end else if (Load) begin
      Bcd   <= clamp_bcd(Load_val);
      Tick  <= 1'b0;
      Carry <= 1'b0;
    end else begin
      Tick  <= step;
      Carry <= step && step_wrap;
      if (step) begin
        Bcd <= step_val;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_counter.sv
// Self-checking bench for bcd_display_counter: directed vector table, hand sequences, random vs. integer model.
module tb_bcd_display_counter;

  localparam int TICK_DIV = 4;
`ifdef BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        aclr = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] bcd;
  logic        tick;
  logic        carry;

  always #5 clk = ~clk;

  bcd_display_counter #(.TICK_DIV(TICK_DIV), .PRESC_W(3)) dut (
    .Clk(clk), .Aclr(aclr), .En(en), .Up_dn(up_dn), .Load(load),
    .Load_val(load_val), .Bcd(bcd), .Tick(tick), .Carry(carry)
  );

  typedef struct {
    logic        aclr;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] lval;
    logic [15:0] exp_bcd;
    logic        exp_tick;
    logic        exp_carry;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: counter value as a plain integer 0..9999
  int   m_val = 0;
  int   m_presc = 0;
  logic m_tick = 1'b0;
  logic m_carry = 1'b0;

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int clampToInt(input logic [15:0] v);
    int r = 0;
    int d;
    for (int i = 3; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic void addVec(input string n, input logic a, input logic e, input logic u,
                                 input logic l, input logic [15:0] lv, input logic [15:0] eb,
                                 input logic et, input logic ec);
    vec_t v;
    v.name = n; v.aclr = a; v.en = e; v.up = u; v.load = l; v.lval = lv;
    v.exp_bcd = eb; v.exp_tick = et; v.exp_carry = ec;
    vecs.push_back(v);
  endfunction

  task automatic modelEdge(input logic a, input logic e, input logic u, input logic l,
                           input logic [15:0] lv);
    if (a) begin
      m_val = 0; m_presc = 0; m_tick = 1'b0; m_carry = 1'b0;
    end else if (l) begin
      m_val = clampToInt(lv); m_presc = 0; m_tick = 1'b0; m_carry = 1'b0;
    end else begin
      m_tick = 1'b0; m_carry = 1'b0;
      if (e) begin
        if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          m_tick  = 1'b1;
          if (u) begin
            if (m_val == 9999) begin
              m_carry = 1'b1;
              if (!SAT) m_val = 0;
            end else m_val = m_val + 1;
          end else begin
            if (m_val == 0) begin
              m_carry = 1'b1;
              if (!SAT) m_val = 9999;
            end else m_val = m_val - 1;
          end
        end else m_presc = m_presc + 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic a, input logic e, input logic u, input logic l,
                               input logic [15:0] lv);
    aclr = a; en = e; up_dn = u; load = l; load_val = lv;
    @(posedge clk);
    modelEdge(a, e, u, l, lv);
    #1;
  endtask

  task automatic checkOutput(input string n, input logic [15:0] eb, input logic et, input logic ec);
    checks++;
    if ({bcd, tick, carry} !== {eb, et, ec}) begin
      errors++;
      $display("[TB] FAIL %s: got Bcd=%h Tick=%b Carry=%b, expected Bcd=%h Tick=%b Carry=%b",
               n, bcd, tick, carry, eb, et, ec);
    end
  endtask

  initial begin
    logic [15:0] picks [6];
    logic [15:0] lv;

    addVec("reset", 1, 0, 1, 0, 16'h0000, 16'h0000, 0, 0);
    for (int k = 1; k <= 12; k++)
      addVec("count_up", 0, 1, 1, 0, 16'h0000, 16'(k / 4), (k % 4) == 0, 0);
    addVec("load_0999", 0, 1, 1, 1, 16'h0999, 16'h0999, 0, 0);
    for (int k = 0; k < 3; k++) addVec("ripple_wait", 0, 1, 1, 0, 16'h0, 16'h0999, 0, 0);
    addVec("ripple_step", 0, 1, 1, 0, 16'h0, 16'h1000, 1, 0);
    addVec("load_9999", 0, 1, 1, 1, 16'h9999, 16'h9999, 0, 0);
    for (int k = 0; k < 3; k++) addVec("wrap_wait", 0, 1, 1, 0, 16'h0, 16'h9999, 0, 0);
    addVec("wrap_up", 0, 1, 1, 0, 16'h0, SAT ? 16'h9999 : 16'h0000, 1, 1);
    addVec("wrap_up_drop", 0, 1, 1, 0, 16'h0, SAT ? 16'h9999 : 16'h0000, 0, 0);
    addVec("load_0000", 0, 1, 0, 1, 16'h0000, 16'h0000, 0, 0);
    for (int k = 0; k < 3; k++) addVec("borrow_wait", 0, 1, 0, 0, 16'h0, 16'h0000, 0, 0);
    addVec("wrap_down", 0, 1, 0, 0, 16'h0, SAT ? 16'h0000 : 16'h9999, 1, 1);
    addVec("wrap_down_drop", 0, 1, 0, 0, 16'h0, SAT ? 16'h0000 : 16'h9999, 0, 0);
    addVec("load_clamp", 0, 0, 1, 1, 16'hA5F3, 16'h9593, 0, 0);
    for (int k = 0; k < 3; k++) addVec("pre_step", 0, 1, 1, 0, 16'h0, 16'h9593, 0, 0);
    addVec("load_beats_step", 0, 1, 1, 1, 16'h1234, 16'h1234, 0, 0);
    for (int k = 0; k < 3; k++) addVec("post_load_wait", 0, 1, 1, 0, 16'h0, 16'h1234, 0, 0);
    addVec("post_load_step", 0, 1, 1, 0, 16'h0, 16'h1235, 1, 0);
    for (int k = 0; k < 2; k++) addVec("mid_count", 0, 1, 1, 0, 16'h0, 16'h1235, 0, 0);
    for (int k = 0; k < 10; k++) addVec("freeze", 0, 0, 1, 0, 16'h0, 16'h1235, 0, 0);
    addVec("resume_wait", 0, 1, 1, 0, 16'h0, 16'h1235, 0, 0);
    addVec("resume_step", 0, 1, 1, 0, 16'h0, 16'h1236, 1, 0);
    for (int k = 0; k < 3; k++) addVec("pre_aclr", 0, 1, 1, 0, 16'h0, 16'h1236, 0, 0);
    addVec("aclr_on_step", 1, 1, 1, 0, 16'h0, 16'h0000, 0, 0);
    addVec("aclr_beats_load", 1, 1, 1, 1, 16'h1111, 16'h0000, 0, 0);
    for (int k = 1; k <= 4; k++)
      addVec("after_aclr", 0, 1, 1, 0, 16'h0, 16'(k / 4), k == 4, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].aclr, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lval);
      checkOutput(vecs[i].name, vecs[i].exp_bcd, vecs[i].exp_tick, vecs[i].exp_carry);
    end

    // Up_dn wiggles between steps; only its step-cycle value should count
    applyStimulus(0, 1, 0, 1, 16'h0500);
    checkOutput("updn_load", 16'h0500, 0, 0);
    applyStimulus(0, 1, 0, 0, 16'h0);
    checkOutput("updn_wait0", 16'h0500, 0, 0);
    applyStimulus(0, 1, 1, 0, 16'h0);
    checkOutput("updn_wait1", 16'h0500, 0, 0);
    applyStimulus(0, 1, 0, 0, 16'h0);
    checkOutput("updn_wait2", 16'h0500, 0, 0);
    applyStimulus(0, 1, 1, 0, 16'h0);
    checkOutput("updn_step", 16'h0501, 1, 0);

    // Random phase against the integer model
    picks[0] = 16'h9999; picks[1] = 16'h0000; picks[2] = 16'h9998;
    picks[3] = 16'h0001; picks[4] = 16'h0990; picks[5] = 16'hFFFF;
    applyStimulus(1, 0, 0, 0, 16'h0);
    checkOutput("rand_reset", toBcd(m_val), m_tick, m_carry);
    for (int n = 0; n < 3000; n++) begin
      lv = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 5)] : 16'($urandom);
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) != 0 ? n[9] : $urandom_range(0, 1) == 1,
                    $urandom_range(0, 31) == 0, lv);
      checkOutput("random", toBcd(m_val), m_tick, m_carry);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_counter.md
Name: bcd_display_counter

Overview:
- 4-digit BCD up/down counter with built-in tick prescaler.
- Sits directly upstream of the 4-digit seven-segment scan driver.
- Its Bcd bus is the display data; digit 0 is the least significant digit and drives COM_1.
- Supports enable, direction, synchronous parallel load, and a one-cycle wrap/carry pulse for cascading.

Parameters:
- TICK_DIV, default 1000: Clk cycles per count step; legal range 2..2^20.
- PRESC_W, default 20: prescaler counter width; must satisfy 2^PRESC_W >= TICK_DIV.

Ports:
- Clk  input  1: system clock; all logic on rising edge.
- Aclr  input  1: reset, synchronous, active-high; clears every register on the next Clk edge.
- En  input  1: count enable; 0 freezes prescaler and digits.
- Up_dn  input  1: 1 = count up, 0 = count down; sampled on the tick cycle.
- Load  input  1: synchronous parallel load strobe.
- Load_val  input  16: four BCD nibbles; [3:0] is digit 0.
- Bcd  output  16: registered counter value, four BCD nibbles.
- Tick  output  1: registered one-cycle pulse, asserted on the cycle Bcd changes due to counting.
- Carry  output  1: registered one-cycle pulse on wrap, 9999->0000 (up) or 0000->9999 (down).

Behaviour:
- Reset:
  - Aclr=1 at an edge sets Bcd=16'h0000, Tick=0, Carry=0, prescaler=0.
  - Aclr has priority over Load and En, including mid-count.
- Prescaler:
  - With En=1 and Load=0, increments each cycle from 0 to TICK_DIV-1, then returns to 0.
  - An internal step fires on the cycle it holds TICK_DIV-1.
  - With En=0 it holds its value; it does not clear.
- Step latency:
  - Bcd, Tick and Carry update on the edge that ends the step cycle.
  - Steps occur every TICK_DIV cycles.
  - The first step after reset lands on the TICK_DIV-th enabled edge.
- Up step:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and propagates an increment to the next digit, rippling combinationally within one cycle.
  - At 9999 all digits become 0 and Carry=1 for one cycle.
- Down step:
  - Mirror of the up step: a digit at 0 becomes 9 and borrows from the next digit.
  - At 0000 all digits become 9 and Carry=1.
- Load:
  - Load=1 (with Aclr=0) sets Bcd=Load_val on the next edge and clears the prescaler.
  - Tick=0 and Carry=0 on that edge.
  - Load beats a simultaneous step; the step is discarded.
  - Load acts regardless of En.
- Invalid BCD:
  - Any Load_val nibble >9 is stored as 9, clamped per digit.
  - Bcd therefore never holds a nibble >9.
- Up_dn:
  - Changing Up_dn between steps has no side effect.
  - Only its value on the step cycle matters.
- Outputs are glitch-free registers and feed the scan driver directly with no handshake.
- The scan driver samples Bcd asynchronously to step timing.

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined:
  - Up step at 9999 holds 9999; down step at 0000 holds 0000.
  - Carry pulses once on the step that attempts to pass the limit, and again on each further blocked step.
  - Tick still pulses.
- Undefined: wrap-around as described in Behaviour.
- Load, reset and clamping are identical in both builds.

Test Plan (TICK_DIV=4 for all benches):
- Reset then En=1, Up_dn=1 for 12 cycles -> Tick pulses on edges 4, 8, 12; Bcd goes 0001, 0002, 0003; Carry stays 0.
- Load Load_val=16'h0999, Up_dn=1, En=1 -> after 4 cycles Bcd=16'h1000, Tick=1, Carry=0.
- Load 16'h9999, up; next step -> Bcd=16'h0000, Carry=1 for exactly one cycle. With BCD_SATURATE_EN -> Bcd stays 16'h9999, Carry=1.
- From 16'h0000, Up_dn=0, one step -> Bcd=16'h9999, Carry=1. With BCD_SATURATE_EN -> Bcd stays 16'h0000.
- Load 16'hA5F3 -> Bcd=16'h9593. Assert Load on the step cycle with Load_val=16'h1234 -> Bcd=16'h1234, Tick=0, next step 4 cycles later gives 1235.
- En=0 for 10 cycles mid-count, then En=1 -> no Tick while En=0; step spacing resumes from the held prescaler value. Aclr=1 during a step cycle -> Bcd=16'h0000, Tick=0.
